// File: rtl/sub1_feeder_if.sv
// Valid/ready bus around sub1_feeder: upstream ingress channel plus the sub1-facing egress channel.
// master = environment side (upstream producer + sub1 consumer), slave = the feeder itself.
interface sub1_feeder_if #(
   parameter int DW = 32
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/sub1_feeder.sv
// Elastic fall-through FIFO feeding sub1: decouples upstream stalls from sub1 backpressure
// and keeps occupancy plus sticky overflow/underflow flags for status.
module sub1_feeder #(
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   sub1_feeder_if.slave                 bus,
   input  logic                         flush,
   input  logic                         err_clr,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         ovf_err,
   output logic                         unf_err
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic          r_ovf_err;
   logic          r_unf_err;

   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;

   // One extra pointer bit distinguishes full from empty when the index bits match.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push  = bus.in_valid & ~w_full;
   assign w_pop   = bus.out_ready & ~w_empty;

   assign bus.in_ready  = ~w_full;
   assign bus.out_valid = ~w_empty;
   assign bus.out_data  = r_mem[r_rd_ptr[AW-1:0]];
   assign count         = r_wr_ptr - r_rd_ptr;
   assign ovf_err       = r_ovf_err;
   assign unf_err       = r_unf_err;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push && !flush) r_mem[r_wr_ptr[AW-1:0]] <= bus.in_data;
   end

   // A set condition in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf_err <= 1'b0;
         r_unf_err <= 1'b0;
      end else begin
         r_ovf_err <= (bus.in_valid & w_full)    | (r_ovf_err & ~err_clr);
         r_unf_err <= (bus.out_ready & w_empty)  | (r_unf_err & ~err_clr);
      end
   end
endmodule

// File: doc/sub1_feeder.md
Name: sub1_feeder

Overview:
- Elastic ingress stage directly upstream of sub1 inside top.
- Accepts words on a valid/ready input and buffers them in a small synchronous FIFO.
- Presents words to sub1 on a valid/ready output, decoupling upstream stalls from sub1 backpressure.
- Exposes occupancy plus sticky error flags for debug and status.

Parameters:
- DW, 32, data word width in bits.
- DEPTH, 4, FIFO entries; power of two, 2..64.
- AW, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  feeder can accept; equals !full.
- in_data  input  DW  upstream word.
- out_valid  output  1  word available to sub1; equals !empty.
- out_ready  input  1  sub1 accepts the word.
- out_data  output  DW  head-of-FIFO word.
- flush  input  1  synchronous clear of contents.
- count  output  AW+1  current occupancy, 0..DEPTH.
- ovf_err  output  1  sticky: in_valid seen while full.
- unf_err  output  1  sticky: out_ready seen while empty.
- err_clr  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, ovf_err=0, unf_err=0.
  - Consequently out_valid=0 and in_ready=1 immediately.
  - Storage array is not reset; out_data is don't-care while out_valid=0.
- Transfers:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Each transfer takes effect on the rising clk edge.
- out_data is driven combinationally from mem[rd_ptr]. There is no output register.
  - Latency from push to out_valid is 1 cycle (fall-through after the write edge).
- Pointers are AW+1 bits and wrap naturally.
  - empty = (wr_ptr == rd_ptr).
  - full = (MSBs differ and lower AW bits are equal).
  - count = wr_ptr - rd_ptr, modulo 2^(AW+1).
- Simultaneous push and pop:
  - Not full and not empty: both pointers advance, count unchanged.
  - Full: in_ready=0, so no push; pop proceeds; next cycle count=DEPTH-1.
  - Empty: out_valid=0, so no pop; push proceeds; next cycle count=1.
- in_ready and out_valid depend only on state, never combinationally on in_valid or out_ready. Both sides are registered-handshake safe.
- Protocol rules the feeder relies on:
  - Upstream holds in_valid and in_data stable until accepted.
  - Once asserted, out_valid stays high and out_data stays stable until pop or flush.
- flush: next edge sets wr_ptr=rd_ptr=0 and count=0.
  - flush has priority over a push or pop in the same cycle; that push is dropped.
  - Sticky flags are unaffected by flush.
- Sticky flags:
  - ovf_err sets on the edge where in_valid=1 and full=1.
  - unf_err sets on the edge where out_ready=1 and empty=1.
  - err_clr clears both flags.
  - If err_clr coincides with a set condition, set wins.
- Reset mid-operation: all contents are lost and state returns to reset values asynchronously. The first accepted word after reset release appears on out_data one edge later.

Test Plan:
- Reset then single push:
  - Stimulus: rst_n low 3 cycles, release; push in_data=32'hA5A5_0001 with out_ready=0.
  - Required: out_valid rises the next cycle, out_data=32'hA5A5_0001, count=1.
- Fill to full with out_ready=0, DEPTH=4:
  - Stimulus: push 0x10, 0x11, 0x12, 0x13.
  - Required: count=4, in_ready=0.
  - Then hold in_valid=1 with 0x14 for one cycle: ovf_err=1, count stays 4, 0x14 never appears at the output.
- Drain and underflow:
  - Stimulus: from full, out_ready=1 for 5 cycles.
  - Required: output order 0x10, 0x11, 0x12, 0x13; count steps 3, 2, 1, 0; unf_err=1 after the 5th cycle; err_clr pulse returns it to 0.
- Streaming with wrap-around:
  - Stimulus: in_valid and out_ready high for 20 cycles, data 0..19.
  - Required: count stays at 1 after the first push; outputs 0..19 in order with no gaps; pointers wrap at least twice.
- Simultaneous push/pop at full:
  - Stimulus: preload 4 words; in_valid=1, out_ready=1 for one cycle.
  - Required: pop only; count=3; next cycle in_ready=1 and the push is accepted.
- Flush and async reset mid-stream:
  - Stimulus: with 3 words stored, assert flush together with a push.
  - Required: next cycle count=0, out_valid=0, pushed word dropped.
  - Then load 2 words and pulse rst_n low mid-cycle: count=0 and out_valid=0 immediately, without waiting for a clock edge.
